decode_core: RTL and testbench

DECODE_CORE -- requirements
Module: decode_core

---
 rtl/decode_core.sv | 90 +++++++++
 tb/tb_decode_core.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/decode_core.sv
// decode_core: 8x16 register file, immediate extender and signed comparator.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module decode_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ra,
  input  logic [2:0]  rb,
  input  logic [2:0]  rw,
  input  logic        we,
  input  logic [15:0] bus_w,
  output logic [15:0] bus_a,
  output logic [15:0] bus_b,
  output logic [15:0] r7,
  input  logic [7:0]  imm_in,
  input  logic        ext_op,
  input  logic        ext_place,
  output logic [15:0] ext_out,
  input  logic [15:0] cmp_a,
  input  logic [15:0] cmp_b,
  output logic        gt,
  output logic        lt,
  output logic        eq
);

  logic [15:0] regs [8];
  logic        wr_en;
  logic        byp_a;
  logic        byp_b;
  logic        byp_7;

  // A write lands only when enabled, not aimed at R0, and not in reset
  assign wr_en = we && (rw != 3'd0) && !reset;

  // Register storage; R0 is held at zero and never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (wr_en) begin
      regs[rw] <= bus_w;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp_a = wr_en && (ra == rw);
  assign byp_b = wr_en && (rb == rw);
  assign byp_7 = wr_en && (rw == 3'd7);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
  assign byp_7 = 1'b0;
`endif

  // Asynchronous read ports with R0 forced to zero and optional forwarding
  always_comb begin
    bus_a = 16'h0000;
    bus_b = 16'h0000;
    r7    = regs[7];
    if (ra != 3'd0) begin
      bus_a = byp_a ? bus_w : regs[ra];
    end
    if (rb != 3'd0) begin
      bus_b = byp_b ? bus_w : regs[rb];
    end
    if (byp_7) begin
      r7 = bus_w;
    end
  end

  // Immediate extender: high-byte placement ignores the sign/zero choice
  always_comb begin
    ext_out = 16'h0000;
    if (ext_place) begin
      ext_out = {imm_in, 8'h00};
    end else if (ext_op) begin
      ext_out = {{8{imm_in[7]}}, imm_in};
    end else begin
      ext_out = {8'h00, imm_in};
    end
  end

  // Signed comparator; the three flags are mutually exclusive by construction
  always_comb begin
    eq = (cmp_a == cmp_b);
    lt = ($signed(cmp_a) < $signed(cmp_b));
    gt = !eq && !lt;
  end

endmodule

// File: tb/tb_decode_core.sv
// tb_decode_core: randomized and directed checks of decode_core
// against a behavioural model of the register file, extender and comparator.
module tb_decode_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ra, rb, rw;
  logic        we;
  logic [15:0] bus_w;
  logic [15:0] bus_a, bus_b, r7;
  logic [7:0]  imm_in;
  logic        ext_op, ext_place;
  logic [15:0] ext_out;
  logic [15:0] cmp_a, cmp_b;
  logic        gt, lt, eq;

  int checks = 0;
  int errors = 0;
  logic [15:0] model [8];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  decode_core dut (
    .clk(clk), .reset(reset),
    .ra(ra), .rb(rb), .rw(rw), .we(we),
    .bus_w(bus_w), .bus_a(bus_a), .bus_b(bus_b), .r7(r7),
    .imm_in(imm_in), .ext_op(ext_op), .ext_place(ext_place),
    .ext_out(ext_out),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .gt(gt), .lt(lt), .eq(eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [2:0] a);
    if (a == 0) return 16'h0000;
    if (BYP && we && !reset && rw == a) return bus_w;
    return model[a];
  endfunction

  function automatic logic [15:0] exp_ext();
    int v;
    if (ext_place) v = int'(imm_in) * 256;
    else if (ext_op && imm_in >= 128) v = int'(imm_in) + 65280;
    else v = int'(imm_in);
    return 16'(v);
  endfunction

  function automatic int sval(input logic [15:0] x);
    return (x >= 16'd32768) ? int'(x) - 65536 : int'(x);
  endfunction

  task automatic check_all();
    int a, b;
    logic [15:0] fl;
    a = sval(cmp_a);
    b = sval(cmp_b);
    fl = {13'b0, a > b, a < b, a == b};
    check("bus_a", bus_a, exp_read(ra));
    check("bus_b", bus_b, exp_read(rb));
    check("r7", r7, exp_read(3'd7));
    check("ext_out", ext_out, exp_ext());
    check("flags", {13'b0, gt, lt, eq}, fl);
  endtask

  task automatic cycle(input bit chk);
    #1;
    if (chk) check_all();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    end else if (we && rw != 0) begin
      model[rw] = bus_w;
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; rw = a; bus_w = d;
    cycle(1'b1);
    we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    reset = 1'b1; we = 1'b0; ra = 0; rb = 0; rw = 0; bus_w = 0;
    imm_in = 0; ext_op = 0; ext_place = 0; cmp_a = 0; cmp_b = 0;
    @(negedge clk);
    cycle(1'b0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i);
      #1;
      check("rst_a", bus_a, 16'h0000);
      check("rst_b", bus_b, 16'h0000);
      check("rst_r7", r7, 16'h0000);
    end

    wr(3'd3, 16'hBEEF);
    ra = 3; rb = 0; #1;
    check("r3_a", bus_a, 16'hBEEF);
    check("r0_b", bus_b, 16'h0000);

    wr(3'd0, 16'h1234);
    ra = 0; #1;
    check("r0_wr", bus_a, 16'h0000);

    wr(3'd7, 16'h3333);
    reset = 1'b1;
    wr(3'd7, 16'h00A5);
    reset = 1'b0; #1;
    check("rst_pri", r7, 16'h0000);
    wr(3'd7, 16'h00A5);
    #1;
    check("r7_wr", r7, 16'h00A5);

    imm_in = 8'h80;
    ext_op = 1; ext_place = 0; #1;
    check("ext_sx", ext_out, 16'hFF80);
    ext_op = 0; #1;
    check("ext_zx", ext_out, 16'h0080);
    ext_place = 1; ext_op = 1; #1;
    check("ext_hi", ext_out, 16'h8000);

    cmp_a = 16'hFFFF; cmp_b = 16'h0001; #1;
    check("cmp_lt", {13'b0, gt, lt, eq}, 16'h0002);
    cmp_a = 16'h7FFF; cmp_b = 16'h8000; #1;
    check("cmp_gt", {13'b0, gt, lt, eq}, 16'h0004);
    cmp_a = 16'h0042; cmp_b = 16'h0042; #1;
    check("cmp_eq", {13'b0, gt, lt, eq}, 16'h0001);

    wr(3'd2, 16'h1111);
    ra = 2; we = 1; rw = 2; bus_w = 16'h5555; #1;
    check("rdw", bus_a, BYP ? 16'h5555 : 16'h1111);
    cycle(1'b1);
    we = 0; #1;
    check("rdw_post", bus_a, 16'h5555);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 19) == 0);
      we = 1'($urandom);
      ra = 3'($urandom); rb = 3'($urandom);
      rw = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom);
      bus_w = 16'($urandom);
      imm_in = 8'($urandom);
      ext_op = 1'($urandom); ext_place = 1'($urandom);
      cmp_a = 16'($urandom);
      cmp_b = ($urandom_range(0, 7) == 0) ? cmp_a : 16'($urandom);
      cycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
